ff_bank_arbiter: RTL and testbench

Shares one WIDTH-bit flip-flop bank between NREQ requesters. Each requester can ask to load data, clear the bank, or set the bank. The block arbitrates round-robin, latches the winning command and drives the bank's tick/d/reset/preset controls for exactly one enabled cycle. It then acknowledges the winner. It sits between client logic and a bank of gated D flip-flops, and keeps a shadow copy of the bank contents for readback.

---
 rtl/ff_bank_arbiter_pkg.sv | 21 ++
 rtl/ff_bank_arbiter_rr_pick.sv | 35 +++
 rtl/ff_bank_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_ff_bank_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_bank_arbiter_pkg.sv
// ff_bank_arbiter_pkg
// Shared definitions for the flip-flop bank arbiter:
//   - the per-requester command encodings
//   - the arbiter FSM state encoding
package ff_bank_arbiter_pkg;

  // Per-requester command codes carried on cmd[2i+1:2i]
  localparam logic [1:0] CMD_LOAD = 2'b00;
  localparam logic [1:0] CMD_CLR  = 2'b01;
  localparam logic [1:0] CMD_SET  = 2'b10;
  localparam logic [1:0] CMD_NOP  = 2'b11;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_DRIVE = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

endpackage

// File: rtl/ff_bank_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin picker. Finds the first set request bit
// starting at index rr and searching upward, wrapping from NREQ-1 to 0.
// Ports:
//   req    in  NREQ  request vector
//   rr     in  IDW   search start index (must be < NREQ)
//   winner out IDW   index of the selected requester (0 when none)
//   valid  out 1     at least one request bit is set
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr,
  output logic [IDW-1:0]  winner,
  output logic            valid
);

  // Walk the offsets from farthest to nearest so the nearest set bit
  // (smallest offset from rr) is the last assignment and therefore wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx[IDW-1:0]]) begin
        winner = idx[IDW-1:0];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ff_bank_arbiter.sv
// ff_bank_arbiter
// Shares one WIDTH-bit gated flip-flop bank between NREQ requesters.
// A request is arbitrated round-robin, its command latched, one strobe
// is issued on the first cycle tick_en allows, and the winner is acked.
// A shadow copy of the bank contents is kept for readback.
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   req       in   NREQ per-requester request levels (held until ack)
//   cmd       in   2*NREQ commands, slice i = cmd[2i+1:2i]
//   data      in   WIDTH*NREQ load data, slice i
//   tick_en   in   bank update permitted this cycle
//   ack       out  NREQ one-cycle one-hot completion pulse
//   busy      out  high whenever the FSM is not idle
//   ff_tick   out  bank load enable
//   ff_d      out  bank data (holds between loads)
//   ff_reset  out  bank synchronous clear
//   ff_preset out  bank synchronous set
//   shadow_q  out  expected bank contents
//   last_id   out  index of the most recently served requester
module ff_bank_arbiter
  import ff_bank_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     cmd,
  input  logic [WIDTH*NREQ-1:0] data,
  input  logic                  tick_en,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  output logic                  ff_tick,
  output logic [WIDTH-1:0]      ff_d,
  output logic                  ff_reset,
  output logic                  ff_preset,
  output logic [WIDTH-1:0]      shadow_q,
  output logic [IDW-1:0]        last_id
);

  logic [1:0]       cmd_arr  [NREQ];
  logic [WIDTH-1:0] data_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign cmd_arr[gi]  = cmd[2*gi +: 2];
    assign data_arr[gi] = data[WIDTH*gi +: WIDTH];
  end

  state_t           state_reg, state_next;
  logic [IDW-1:0]   rr_reg, rr_next;
  logic [IDW-1:0]   win_reg, win_next;
  logic [1:0]       cmd_reg, cmd_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [NREQ-1:0]  ack_reg, ack_next;
  logic             busy_reg, busy_next;
  logic             tick_reg, tick_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic             clr_reg, clr_next;
  logic             set_reg, set_next;
  logic [WIDTH-1:0] shadow_reg, shadow_next;
  logic [IDW-1:0]   last_reg, last_next;

  logic [IDW-1:0]   pick_id;
  logic             pick_valid;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req    (req),
    .rr     (rr_reg),
    .winner (pick_id),
    .valid  (pick_valid)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      rr_reg     <= '0;
      win_reg    <= '0;
      cmd_reg    <= CMD_NOP;
      data_reg   <= '0;
      ack_reg    <= '0;
      busy_reg   <= 1'b0;
      tick_reg   <= 1'b0;
      d_reg      <= '0;
      clr_reg    <= 1'b0;
      set_reg    <= 1'b0;
      shadow_reg <= '0;
      last_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      rr_reg     <= rr_next;
      win_reg    <= win_next;
      cmd_reg    <= cmd_next;
      data_reg   <= data_next;
      ack_reg    <= ack_next;
      busy_reg   <= busy_next;
      tick_reg   <= tick_next;
      d_reg      <= d_next;
      clr_reg    <= clr_next;
      set_reg    <= set_next;
      shadow_reg <= shadow_next;
      last_reg   <= last_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    rr_next     = rr_reg;
    win_next    = win_reg;
    cmd_next    = cmd_reg;
    data_next   = data_reg;
    ack_next    = '0;
    tick_next   = 1'b0;
    d_next      = d_reg;
    clr_next    = 1'b0;
    set_next    = 1'b0;
    shadow_next = shadow_reg;
    last_next   = last_reg;

    case (state_reg)
      ST_IDLE: begin
        if (|req) state_next = ST_ARB;
      end
      ST_ARB: begin
        // Requests may have been withdrawn since IDLE saw them.
        if (pick_valid) begin
          win_next   = pick_id;
          cmd_next   = cmd_arr[pick_id];
          data_next  = data_arr[pick_id];
          state_next = ST_DRIVE;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        // The registered strobe and the shadow update land on the same edge.
        if (tick_en) begin
          case (cmd_reg)
            CMD_LOAD: begin
              tick_next   = 1'b1;
              d_next      = data_reg;
              shadow_next = data_reg;
            end
            CMD_CLR: begin
              clr_next    = 1'b1;
              shadow_next = '0;
            end
            CMD_SET: begin
              set_next    = 1'b1;
              shadow_next = '1;
            end
            CMD_NOP: ;
            default: ;
          endcase
          state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        ack_next[win_reg] = 1'b1;
        last_next         = win_reg;
        rr_next           = (win_reg == IDW'(NREQ - 1)) ? '0 : win_reg + IDW'(1);
        state_next        = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Registered busy tracks the state the FSM is about to enter.
    busy_next = (state_next != ST_IDLE);
  end

  assign ack       = ack_reg;
  assign busy      = busy_reg;
  assign ff_tick   = tick_reg;
  assign ff_d      = d_reg;
  assign ff_reset  = clr_reg;
  assign ff_preset = set_reg;
  assign shadow_q  = shadow_reg;
  assign last_id   = last_reg;

endmodule

// File: tb/tb_ff_bank_arbiter.sv
// tb_ff_bank_arbiter
// Directed scenarios followed by randomized traffic; a transaction-level
// reference model tracks each request from acceptance to acknowledge and
// is compared against the DUT every cycle.
module tb_ff_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clock;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     cmd;
  logic [WIDTH*NREQ-1:0] data;
  logic                  tick_en;
  logic [NREQ-1:0]       ack;
  logic                  busy;
  logic                  ff_tick;
  logic [WIDTH-1:0]      ff_d;
  logic                  ff_reset;
  logic                  ff_preset;
  logic [WIDTH-1:0]      shadow_q;
  logic [IDW-1:0]        last_id;

  ff_bank_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .IDW   (IDW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .cmd       (cmd),
    .data      (data),
    .tick_en   (tick_en),
    .ack       (ack),
    .busy      (busy),
    .ff_tick   (ff_tick),
    .ff_d      (ff_d),
    .ff_reset  (ff_reset),
    .ff_preset (ff_preset),
    .shadow_q  (shadow_q),
    .last_id   (last_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // One transaction at a time: accepted, then committed to a winner,
  // then its bank effect applied, then acknowledged.
  logic [NREQ-1:0]  m_ack = '0;
  logic             m_tick = 1'b0, m_clr = 1'b0, m_set = 1'b0;
  logic [WIDTH-1:0] m_d = '0, m_shadow = '0;
  logic [IDW-1:0]   m_last = '0;
  int               m_ptr = 0;
  bit               m_active = 0, m_committed = 0, m_applied = 0;
  int               m_id = 0;
  logic [1:0]       m_cmd = 2'b11;
  logic [WIDTH-1:0] m_data = '0;

  task automatic model_reset();
    m_ack = '0; m_tick = 0; m_clr = 0; m_set = 0;
    m_d = '0; m_shadow = '0; m_last = '0; m_ptr = 0;
    m_active = 0; m_committed = 0; m_applied = 0;
  endtask

  task automatic model_step();
    bit found;
    m_ack = '0; m_tick = 0; m_clr = 0; m_set = 0;
    if (!m_active) begin
      if (req != '0) begin
        m_active = 1; m_committed = 0; m_applied = 0;
      end
    end else if (!m_committed) begin
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (!found && req[i]) begin
          found = 1;
          m_id = i;
        end
      end
      if (!found) m_active = 0;
      else begin
        m_committed = 1;
        m_cmd  = cmd[2*m_id +: 2];
        m_data = data[WIDTH*m_id +: WIDTH];
      end
    end else if (!m_applied) begin
      if (tick_en) begin
        m_applied = 1;
        case (m_cmd)
          2'b00: begin m_tick = 1; m_d = m_data; m_shadow = m_data; end
          2'b01: begin m_clr = 1; m_shadow = '0; end
          2'b10: begin m_set = 1; m_shadow = '1; end
          default: ;
        endcase
      end
    end else begin
      m_ack[m_id] = 1'b1;
      m_last = m_id[IDW-1:0];
      m_ptr = (m_id + 1) % NREQ;
      m_active = 0;
    end
  endtask

  // ---------------- per-cycle compare process ----------------
  always @(posedge clock) begin
    cyc++;
    if (!reset) model_reset();
    else model_step();
    #1;
    if (reset) begin
      check("ack", 32'(ack), 32'(m_ack));
      check("busy", 32'(busy), 32'(m_active));
      check("ff_tick", 32'(ff_tick), 32'(m_tick));
      check("ff_reset", 32'(ff_reset), 32'(m_clr));
      check("ff_preset", 32'(ff_preset), 32'(m_set));
      check("ff_d", 32'(ff_d), 32'(m_d));
      check("shadow_q", 32'(shadow_q), 32'(m_shadow));
      check("last_id", 32'(last_id), 32'(m_last));
      if (m_ack != '0)
        $display("txn cyc=%0d id=%0d cmd=%0d shadow=%02h", cyc, m_id, m_cmd, m_shadow);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input logic [1:0] c, input logic [7:0] d);
    req[i] = v;
    cmd[2*i +: 2] = c;
    data[WIDTH*i +: WIDTH] = d;
  endtask

  task automatic wait_ack(output logic [NREQ-1:0] a, output int at);
    a = '0;
    at = 0;
    for (int n = 0; n < 16; n++) begin
      wait_edges(1);
      if (ack != '0) begin
        a = ack;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, 32'(ack), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_strobes"}, 32'({ff_tick, ff_reset, ff_preset}), 32'h0);
    check({tag, "_ff_d"}, 32'(ff_d), 32'h0);
    check({tag, "_shadow"}, 32'(shadow_q), 32'h0);
    check({tag, "_last_id"}, 32'(last_id), 32'h0);
  endtask

  // Asserts reset away from the clock edge and checks the immediate clear.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all_zero(tag);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] a;
    int at, prev_at;
    int order [5] = '{0, 1, 2, 3, 0};

    reset = 1'b0;
    req = '0;
    cmd = '1;
    data = '0;
    tick_en = 1'b0;
    wait_edges(3);
    check_all_zero("rst");
    @(negedge clock);
    reset = 1'b1;

    // Single load from requester 1
    @(negedge clock);
    tick_en = 1'b1;
    set_req(1, 1, 2'b00, 8'hA5);
    wait_edges(3);
    check("t1_tick", 32'(ff_tick), 32'h1);
    check("t1_d", 32'(ff_d), 32'hA5);
    wait_edges(1);
    check("t1_ack", 32'(ack), 32'h2);
    check("t1_shadow", 32'(shadow_q), 32'hA5);
    check("t1_last", 32'(last_id), 32'h1);
    check("t1_model_shadow", 32'(m_shadow), 32'hA5);
    check("t1_model_last", 32'(m_last), 32'h1);
    @(negedge clock);
    set_req(1, 0, 2'b11, 8'h00);

    // Clear then set from requester 0
    @(negedge clock);
    set_req(0, 1, 2'b01, 8'h00);
    wait_edges(3);
    check("t2_clr", 32'(ff_reset), 32'h1);
    check("t2_clr_only", 32'({ff_tick, ff_preset}), 32'h0);
    wait_edges(1);
    check("t2_ack_clr", 32'(ack), 32'h1);
    check("t2_shadow_clr", 32'(shadow_q), 32'h00);
    check("t2_clr_pulse", 32'(ff_reset), 32'h0);
    @(negedge clock);
    set_req(0, 1, 2'b10, 8'h00);
    wait_edges(3);
    check("t2_set", 32'(ff_preset), 32'h1);
    check("t2_set_only", 32'({ff_tick, ff_reset}), 32'h0);
    wait_edges(1);
    check("t2_ack_set", 32'(ack), 32'h1);
    check("t2_shadow_set", 32'(shadow_q), 32'hFF);
    @(negedge clock);
    set_req(0, 0, 2'b11, 8'h00);

    // Stall in DRIVE for five cycles
    @(negedge clock);
    tick_en = 1'b0;
    set_req(2, 1, 2'b00, 8'h3C);
    wait_edges(2);
    for (int s = 0; s < 5; s++) begin
      wait_edges(1);
      check("t4_stall_tick", 32'(ff_tick), 32'h0);
      check("t4_stall_busy", 32'(busy), 32'h1);
    end
    @(negedge clock);
    tick_en = 1'b1;
    wait_edges(1);
    check("t4_tick", 32'(ff_tick), 32'h1);
    check("t4_d", 32'(ff_d), 32'h3C);
    wait_edges(1);
    check("t4_ack", 32'(ack), 32'h4);
    @(negedge clock);
    set_req(2, 0, 2'b11, 8'h00);

    // Withdrawal before ARB, then drop inside DRIVE
    @(negedge clock);
    set_req(2, 1, 2'b01, 8'h00);
    @(negedge clock);
    set_req(2, 0, 2'b01, 8'h00);
    wait_edges(1);
    check("t5_idle", 32'(busy), 32'h0);
    for (int s = 0; s < 4; s++) begin
      wait_edges(1);
      check("t5_no_ack", 32'(ack), 32'h0);
      check("t5_no_strobe", 32'(ff_reset), 32'h0);
    end
    @(negedge clock);
    set_req(2, 1, 2'b01, 8'h00);
    wait_edges(2);
    @(negedge clock);
    set_req(2, 0, 2'b01, 8'h00);
    wait_edges(1);
    check("t5_clr", 32'(ff_reset), 32'h1);
    check("t5_shadow", 32'(shadow_q), 32'h00);
    wait_edges(1);
    check("t5_ack", 32'(ack), 32'h4);

    // Async reset during DRIVE, then rr restarts at 0
    @(negedge clock);
    tick_en = 1'b0;
    set_req(3, 1, 2'b10, 8'h00);
    wait_edges(2);
    check("t6_busy", 32'(busy), 32'h1);
    set_req(0, 1, 2'b00, 8'h5A);
    async_reset("t6");
    tick_en = 1'b1;
    wait_ack(a, at);
    check("t6_first", 32'(a), 32'h1);
    check("t6_shadow0", 32'(shadow_q), 32'h5A);
    set_req(0, 0, 2'b11, 8'h00);
    wait_ack(a, at);
    check("t6_second", 32'(a), 32'h8);
    check("t6_shadow3", 32'(shadow_q), 32'hFF);
    set_req(3, 0, 2'b11, 8'h00);

    // Fairness with all requesters held high
    @(negedge clock);
    async_reset("t3");
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 2'b00, 8'(8'h11 * (i + 1)));
    prev_at = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ack(a, at);
      check("t3_order", 32'(a), 32'(1 << order[k]));
      check("t3_shadow", 32'(shadow_q), 32'(8'h11 * (order[k] + 1)));
      if (k > 0) check("t3_interval", 32'(at - prev_at), 32'd4);
      prev_at = at;
    end
    @(negedge clock);
    req = '0;
    wait_edges(6);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if ($urandom_range(0, 599) == 0) async_reset("rnd_rst");
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && ack[i]) req[i] = 1'b0;
        else if (req[i] && $urandom_range(0, 29) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0)
          set_req(i, 1, 2'($urandom_range(0, 3)), 8'($urandom));
      end
      tick_en = ($urandom_range(0, 3) != 0);
    end

    @(negedge clock);
    req = '0;
    wait_edges(8);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
